// File: rtl/iob_reg_skid_pkg.sv
// rtl/iob_reg_skid_pkg.sv - shared state encoding and constants for the skid buffer
package iob_reg_skid_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam int LEVEL_W = 2;

endpackage

// File: rtl/iob_skid_slot.sv
// rtl/iob_skid_slot.sv - load-enabled data register with synchronous reset
//
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - synchronous active-high reset, loads RST_VAL
//   en_i   - load enable
//   d_i    - data to load
//   q_o    - registered data
module iob_skid_slot #(
    parameter int                 DATA_W  = 21,
    parameter logic [DATA_W-1:0]  RST_VAL = {DATA_W{1'b0}}
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [DATA_W-1:0] d_i,
    output logic [DATA_W-1:0] q_o
);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_o <= RST_VAL;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/iob_reg_skid.sv
// rtl/iob_reg_skid.sv - two-entry valid/ready register slice (skid buffer)
//
// Ports:
//   clk_i, rst_i          - clock and synchronous active-high reset
//   flush_i               - discard buffered words (synchronous)
//   s_valid_i/s_ready_o/s_data_i - upstream handshake and payload
//   m_valid_o/m_ready_i/m_data_o - downstream handshake and payload
//   level_o               - number of buffered words (0..2)
module iob_reg_skid
    import iob_reg_skid_pkg::*;
#(
    parameter int                 DATA_W  = 21,
    parameter logic [DATA_W-1:0]  RST_VAL = {DATA_W{1'b0}}
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic               s_valid_i,
    output logic               s_ready_o,
    input  logic [DATA_W-1:0]  s_data_i,
    output logic               m_valid_o,
    input  logic               m_ready_i,
    output logic [DATA_W-1:0]  m_data_o,
    output logic [LEVEL_W-1:0] level_o
);

    state_t            state_q;
    state_t            state_d;
    logic              push;
    logic              pop;
    logic              main_en;
    logic              skid_en;
    logic [DATA_W-1:0] main_d;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;

    // Upstream ready comes only from registered state plus rst/flush, so
    // m_ready_i never reaches s_ready_o combinationally.
    assign s_ready_o = ~rst_i & ~flush_i & (state_q != FULL);
    assign m_valid_o = (state_q != EMPTY);
    assign m_data_o  = main_q;

    assign push = s_valid_i & s_ready_o;
    assign pop  = m_valid_o & m_ready_i;

    // Main slot refills from the skid slot when draining FULL, else from upstream.
    assign main_d  = (state_q == FULL) ? skid_q : s_data_i;
    // Flush gating keeps both slots untouched in the flush cycle, even when a
    // pop in FULL would otherwise move the skid word forward.
    assign main_en = ~flush_i & ((push & ((state_q == EMPTY) | pop)) |
                                 ((state_q == FULL) & pop));
    assign skid_en = (state_q == ONE) & push & ~pop;

    iob_skid_slot #(.DATA_W(DATA_W), .RST_VAL(RST_VAL)) u_main (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (main_en),
        .d_i   (main_d),
        .q_o   (main_q)
    );

    iob_skid_slot #(.DATA_W(DATA_W), .RST_VAL(RST_VAL)) u_skid (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (skid_en),
        .d_i   (s_data_i),
        .q_o   (skid_q)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        level_o = '0;
        unique case (state_q)
            EMPTY: level_o = LEVEL_W'(0);
            ONE:   level_o = LEVEL_W'(1);
            FULL:  level_o = LEVEL_W'(2);
            default: level_o = '0;
        endcase
        if (flush_i) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: if (push) state_d = ONE;
                ONE: begin
                    if (push & ~pop)      state_d = FULL;
                    else if (~push & pop) state_d = EMPTY;
                end
                FULL:  if (pop) state_d = ONE;
                default: state_d = EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_iob_reg_skid.sv
// tb/tb_iob_reg_skid.sv - self-checking bench for iob_reg_skid
module tb_iob_reg_skid;

    localparam int DATA_W = 21;
    localparam logic [DATA_W-1:0] RST_VAL = '0;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic              flush_i = 1'b0;
    logic              s_valid_i = 1'b0;
    logic              s_ready_o;
    logic [DATA_W-1:0] s_data_i = '0;
    logic              m_valid_o;
    logic              m_ready_i = 1'b0;
    logic [DATA_W-1:0] m_data_o;
    logic [1:0]        level_o;

    iob_reg_skid #(.DATA_W(DATA_W), .RST_VAL(RST_VAL)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .flush_i   (flush_i),
        .s_valid_i (s_valid_i),
        .s_ready_o (s_ready_o),
        .s_data_i  (s_data_i),
        .m_valid_o (m_valid_o),
        .m_ready_i (m_ready_i),
        .m_data_o  (m_data_o),
        .level_o   (level_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: a queue of buffered words plus the last word shown downstream.
    logic [DATA_W-1:0] q[$];
    logic [DATA_W-1:0] shown = RST_VAL;
    logic              m_push = 1'b0;
    logic              chk_en = 1'b0;
    logic [DATA_W-1:0] log_q[$];   // words the DUT actually handed downstream

    always @(posedge clk_i) begin
        logic rdy, vld, pu, po;
        if (m_valid_o === 1'b1 && m_ready_i) log_q.push_back(m_data_o);
        if (rst_i) begin
            q.delete();
            shown  = RST_VAL;
            m_push = 1'b0;
            chk_en = 1'b1;
        end else begin
            rdy = !flush_i && (q.size() < 2);
            vld = (q.size() > 0);
            pu  = s_valid_i && rdy;
            po  = vld && m_ready_i;
            if (po) void'(q.pop_front());
            if (flush_i) q.delete();
            else if (pu) q.push_back(s_data_i);
            if (q.size() > 0) shown = q[0];
            m_push = pu;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk_i) begin
        if (chk_en) begin
            check("s_ready", 32'(s_ready_o), 32'(!rst_i && !flush_i && q.size() < 2));
            check("m_valid", 32'(m_valid_o), 32'(q.size() > 0));
            check("m_data",  32'(m_data_o),  32'(shown));
            check("level",   32'(level_o),   32'(q.size()));
        end
    end

    task automatic drive(input logic r, input logic f, input logic sv,
                         input logic [DATA_W-1:0] sd, input logic mr);
        @(posedge clk_i);
        #1;
        rst_i = r; flush_i = f; s_valid_i = sv; s_data_i = sd; m_ready_i = mr;
    endtask

    task automatic check_log(input string name, input logic [DATA_W-1:0] exp[$]);
        check({name, "_count"}, 32'(log_q.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < log_q.size(); i++)
            check(name, 32'(log_q[i]), 32'(exp[i]));
        log_q.delete();
    endtask

    initial begin
        logic [DATA_W-1:0] exp[$];
        logic              sv;
        logic [DATA_W-1:0] sd;

        // Reset held 3 cycles with a word offered.
        for (int i = 0; i < 3; i++) drive(1, 0, 1, 21'h1ABCDE, 0);
        drive(0, 0, 0, 0, 0);
        @(negedge clk_i);
        check("rst_m_valid", 32'(m_valid_o), 0);
        check("rst_m_data",  32'(m_data_o), 0);
        check("rst_level",   32'(level_o), 0);
        check("rst_s_ready", 32'(s_ready_o), 1);
        log_q.delete();

        // Streaming 1..16 with downstream always ready.
        for (int i = 1; i <= 16; i++) drive(0, 0, 1, DATA_W'(i), 1);
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1);
        exp.delete();
        for (int i = 1; i <= 16; i++) exp.push_back(DATA_W'(i));
        check_log("stream", exp);

        // Back-pressure: two words fit, third waits upstream.
        drive(0, 0, 1, 21'h11, 0);
        drive(0, 0, 1, 21'h22, 0);
        drive(0, 0, 1, 21'h33, 0);
        @(negedge clk_i);
        check("bp_s_ready", 32'(s_ready_o), 0);
        check("bp_level",   32'(level_o), 2);
        check("bp_m_data",  32'(m_data_o), 32'h11);
        drive(0, 0, 1, 21'h33, 1);
        drive(0, 0, 1, 21'h33, 1);
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1);
        exp.delete();
        exp.push_back(21'h11); exp.push_back(21'h22); exp.push_back(21'h33);
        check_log("bp_order", exp);

        // Simultaneous push and pop in ONE.
        drive(0, 0, 1, 21'h44, 0);
        drive(0, 0, 1, 21'h55, 1);
        drive(0, 0, 0, 0, 0);
        @(negedge clk_i);
        check("pp_m_data", 32'(m_data_o), 32'h55);
        check("pp_level",  32'(level_o), 1);
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0);
        log_q.delete();

        // Flush in FULL with a pop in the same cycle.
        drive(0, 0, 1, 21'h66, 0);
        drive(0, 0, 1, 21'h77, 0);
        drive(0, 1, 0, 0, 1);
        drive(0, 0, 0, 0, 1);
        @(negedge clk_i);
        check("fl_m_valid", 32'(m_valid_o), 0);
        check("fl_level",   32'(level_o), 0);
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1);
        exp.delete();
        exp.push_back(21'h66);
        check_log("fl_consumed", exp);

        // Reset in FULL, then new traffic without stale words.
        drive(0, 0, 1, 21'hA1, 0);
        drive(0, 0, 1, 21'hA2, 0);
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        @(negedge clk_i);
        check("mr_level",  32'(level_o), 0);
        check("mr_m_data", 32'(m_data_o), 32'(RST_VAL));
        drive(0, 0, 1, 21'h88, 1);
        drive(0, 0, 1, 21'h99, 1);
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1);
        exp.delete();
        exp.push_back(21'h88); exp.push_back(21'h99);
        check_log("mr_order", exp);

        // Randomized traffic; producer holds its word until accepted.
        sv = 1'b0;
        sd = '0;
        for (int i = 0; i < 3000; i++) begin
            if (!(sv && !m_push)) begin
                sv = ($urandom_range(0, 3) != 0);
                sd = DATA_W'($urandom);
            end
            drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 59) == 0),
                  sv, sd, ($urandom_range(0, 2) != 0));
        end
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1);
        @(negedge clk_i);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/iob_reg_skid.md
# iob_reg_skid

Two-entry valid/ready register slice (skid buffer) that sits between a producer and a consumer in the cache datapath. It accepts one word per cycle from the upstream side and presents it, registered, to the downstream side. It absorbs one cycle of downstream back-pressure without a combinational path from `m_ready_i` to `s_ready_o`. It is the read/drain side of an enable-loaded register: the producer writes words in, and the consumer pulls them out under handshake.

## Interface
- `DATA_W`, default 21: payload width.
- `RST_VAL`, default `{DATA_W{1'b0}}`: reset value of both data slots and of `m_data_o`.

- `clk_i`  in  1  single clock; all state updates on the rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `flush_i`  in  1  synchronous flush; discards buffered words.
- `s_valid_i`  in  1  upstream word valid.
- `s_ready_o`  out  1  slice can accept a word this cycle.
- `s_data_i`  in  DATA_W  upstream payload.
- `m_valid_o`  out  1  `m_data_o` holds a valid word.
- `m_ready_i`  in  1  downstream accepts the word this cycle.
- `m_data_o`  out  DATA_W  downstream payload, driven directly from the main slot flop.
- `level_o`  out  2  number of buffered words (0..2).

## Operation
- `push = s_valid_i & s_ready_o`; `pop = m_valid_o & m_ready_i`.
- Storage:
  - main slot `main_q` drives `m_data_o`.
  - skid slot `skid_q`.
  - state register `{EMPTY, ONE, FULL}`.
- Combinational outputs:
  - `s_ready_o = ~rst_i & ~flush_i & (state != FULL)`.
  - `m_valid_o = (state != EMPTY)`.
  - `level_o` is 0, 1 or 2 for EMPTY, ONE or FULL respectively.
- Transitions:
  - EMPTY, push: `main_q <= s_data_i`, go to ONE. No push: hold.
  - ONE, push and pop: `main_q <= s_data_i`, stay in ONE.
  - ONE, push only: `skid_q <= s_data_i`, go to FULL.
  - ONE, pop only: go to EMPTY; `main_q` holds its stale value.
  - ONE, neither: hold.
  - FULL, pop: `main_q <= skid_q`, go to ONE. No push can occur because `s_ready_o` is 0.
  - FULL, no pop: hold.
- Ordering: strict FIFO order; no word is duplicated or lost while `flush_i` and `rst_i` are low.
- Flush:
  - Next state is EMPTY; data slots hold their values.
  - A pop in the flush cycle completes normally from the consumer's view; the word is consumed.
  - No push is possible in the flush cycle because `s_ready_o` is 0.
- Reset:
  - Has priority over flush and handshakes.
  - State becomes EMPTY; `main_q` and `skid_q` become `RST_VAL`.
  - Reset asserted mid-transfer drops all buffered words.
- Data width: payload is passed unmodified; there is no arithmetic on data.

## Timing
- Latency: a word accepted at edge N is visible on `m_data_o` with `m_valid_o = 1` after edge N (1 cycle).
- Throughput: 1 word per cycle sustained while `m_ready_i = 1`.
- `s_ready_o` depends only on state, `rst_i` and `flush_i`; it never depends on `m_ready_i` or `s_valid_i`.
- `m_valid_o` and `m_data_o` are pure flop outputs.
- Output values after reset:
  - `m_valid_o = 0`, `m_data_o = RST_VAL`, `level_o = 0`.
  - `s_ready_o = 0` while `rst_i = 1`, and 1 in the first cycle after release.
- Once `m_valid_o = 1`, `m_valid_o` and `m_data_o` stay stable until pop, flush or reset.
- Upstream rule: the producer keeps `s_valid_i` and `s_data_i` stable until push; the slice relies on this and does not check it.
- Downstream stall: with `m_ready_i` stuck at 0, exactly 2 words are accepted, then `s_ready_o` drops in the cycle after the second push.

## Structure
- Package `iob_reg_skid_pkg`:
  - state enum `EMPTY = 2'd0`, `ONE = 2'd1`, `FULL = 2'd2`.
  - level width constant `LEVEL_W = 2`.
- Sub-module `iob_skid_slot`: `DATA_W`-wide flop with synchronous reset to `RST_VAL` and a load enable. Instantiated twice (main and skid).
  - Main slot load data: `skid_q` when state is FULL, otherwise `s_data_i`.
  - Main slot load enable: `push & (EMPTY | pop)`, or `FULL & pop`.
  - Skid slot load enable: `ONE & push & ~pop`.
- Top level contains only the state register, the output decode, and the slot enable and mux logic.

## Test plan
- Reset with `DATA_W = 21`: hold `rst_i` for 3 cycles while `s_valid_i = 1`, `s_data_i = 0x1ABCDE`.
  - During reset: `s_ready_o = 0`.
  - After release: `m_valid_o = 0`, `m_data_o = 0`, `level_o = 0`; no word accepted.
- Streaming: push 0x000001..0x000010 on consecutive cycles with `m_ready_i = 1`.
  - Outputs appear in order, one cycle later, with no bubbles; `level_o` stays 1.
- Back-pressure: `m_ready_i = 0`, offer 0x11, 0x22, 0x33.
  - 0x11 and 0x22 are accepted; `s_ready_o` goes to 0 and `level_o = 2`; 0x33 is held upstream.
  - Release `m_ready_i`: outputs are 0x11, 0x22, 0x33 in order.
- Simultaneous push and pop in ONE with 0x44 buffered, pushing 0x55 with `m_ready_i = 1`:
  - Next cycle `m_data_o = 0x55` and `level_o = 1`.
- Flush in FULL (0x66, 0x77 buffered) with `m_ready_i = 1`:
  - 0x66 is consumed in the flush cycle.
  - Next cycle `m_valid_o = 0` and `level_o = 0`; 0x77 is never presented.
- Reset mid-stream in FULL:
  - Next cycle `level_o = 0` and `m_data_o = RST_VAL`.
  - Following pushes 0x88, 0x99 emerge with no stale words.
